id_ex_stage: RTL

- ID/EX pipeline register for the 5-stage MIPS core, with load-use hazard detection, bubble insertion, branch flush and a global hold.
- Sits between decode/register-file read and EX.
- Its registered rs/rt/rd and control outputs drive the EX-stage forwarding unit (IDEX_Rs/IDEX_Rt inputs) and the ALU operand muxes.
- Stall outputs gate the PC and IF/ID registers.

---
 rtl/core_pkg.sv | 30 +++
 rtl/id_ex_stage_if.sv | 45 ++++
 rtl/id_ex_stage_hazard_detect.sv | 27 ++
 rtl/id_ex_stage.sv | 110 +++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage MIPS core: control bundle layout and
// architectural constants used by the pipeline registers and hazard logic.
package core_pkg;

    localparam int CTRL_W = 10;

    // Bit positions inside the packed control bundle, MSB first
    localparam int CTRL_REG_WRITE  = 9;
    localparam int CTRL_MEM_READ   = 8;
    localparam int CTRL_MEM_WRITE  = 7;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_ALU_SRC    = 5;
    localparam int CTRL_REG_DST    = 4;
    localparam int CTRL_ALU_OP_MSB = 3;
    localparam int CTRL_ALU_OP_LSB = 0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;
    localparam logic [4:0]        REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute boundary signals: ID-side inputs, control strobes and the
// registered ID/EX outputs consumed by EX, forwarding and fetch.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 16
);
    logic              hold;
    logic              flush;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic              id_uses_rt;
    logic [DATA_W-1:0] id_rdata1;
    logic [DATA_W-1:0] id_rdata2;
    logic [DATA_W-1:0] id_imm;
    logic [CTRL_W-1:0] id_ctrl;

    logic [4:0]        idex_rs;
    logic [4:0]        idex_rt;
    logic [4:0]        idex_rd;
    logic [DATA_W-1:0] idex_rdata1;
    logic [DATA_W-1:0] idex_rdata2;
    logic [DATA_W-1:0] idex_imm;
    logic [CTRL_W-1:0] idex_ctrl;
    logic              pc_write;
    logic              ifid_write;
    logic              load_use_stall;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output hold, flush, id_rs, id_rt, id_rd, id_uses_rt,
               id_rdata1, id_rdata2, id_imm, id_ctrl,
        input  idex_rs, idex_rt, idex_rd, idex_rdata1, idex_rdata2, idex_imm,
               idex_ctrl, pc_write, ifid_write, load_use_stall, stall_count
    );

    modport slave (
        input  hold, flush, id_rs, id_rt, id_rd, id_uses_rt,
               id_rdata1, id_rdata2, id_imm, id_ctrl,
        output idex_rs, idex_rt, idex_rd, idex_rdata1, idex_rdata2, idex_imm,
               idex_ctrl, pc_write, ifid_write, load_use_stall, stall_count
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use detector: the load in EX writes a register that the
// instruction in ID reads, so ID must wait one cycle for MEM/WB forwarding.
module hazard_detect
    import core_pkg::*;
(
    input  logic       idex_mem_read_i,
    input  logic [4:0] idex_rt_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic       flush_i,
    input  logic       hold_i,
    output logic       load_use_stall_o
);

    logic rs_match;
    logic rt_match;
    logic hazard;

    assign rs_match = (idex_rt_i == id_rs_i);
    assign rt_match = id_uses_rt_i && (idex_rt_i == id_rt_i);
    // $0 is hardwired, so a load targeting it never produces a dependency
    assign hazard   = idex_mem_read_i && (idex_rt_i != REG_ZERO) && (rs_match || rt_match);

    assign load_use_stall_o = hazard && !flush_i && !hold_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// global hold and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = core_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input logic           clk,
    input logic           rst_n,
    id_ex_stage_if.slave  bus
);
    import core_pkg::*;

    logic [4:0]        rs_q, rs_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        rd_q, rd_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stall;

    hazard_detect u_hazard (
        .idex_mem_read_i  (ctrl_q[CTRL_MEM_READ]),
        .idex_rt_i        (rt_q),
        .id_rs_i          (bus.id_rs),
        .id_rt_i          (bus.id_rt),
        .id_uses_rt_i     (bus.id_uses_rt),
        .flush_i          (bus.flush),
        .hold_i           (bus.hold),
        .load_use_stall_o (stall)
    );

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first, so
        // no path through the priority chain leaves one unassigned (no latches).
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        imm_d    = imm_q;
        ctrl_d   = ctrl_q;
        cnt_d    = cnt_q;

        if (!bus.hold) begin
            if (bus.flush || stall) begin
                rs_d     = REG_ZERO;
                rt_d     = REG_ZERO;
                rd_d     = REG_ZERO;
                rdata1_d = '0;
                rdata2_d = '0;
                imm_d    = '0;
                ctrl_d   = CTRL_W'(CTRL_NOP);
            end else begin
                rs_d     = bus.id_rs;
                rt_d     = bus.id_rt;
                rd_d     = bus.id_rd;
                rdata1_d = bus.id_rdata1;
                rdata2_d = bus.id_rdata2;
                imm_d    = bus.id_imm;
                ctrl_d   = bus.id_ctrl;
            end
            // stall already excludes flush, so a squashed hazard is not counted
            if (stall && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: the whole stage is reset, not just ctrl: a zero ctrl is a NOP, and
    // zeroed rs/rt keep the forwarding unit quiet on the first cycles after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            ctrl_q   <= '0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.idex_rs        = rs_q;
    assign bus.idex_rt        = rt_q;
    assign bus.idex_rd        = rd_q;
    assign bus.idex_rdata1    = rdata1_q;
    assign bus.idex_rdata2    = rdata2_q;
    assign bus.idex_imm       = imm_q;
    assign bus.idex_ctrl      = ctrl_q;
    assign bus.stall_count    = cnt_q;
    assign bus.load_use_stall = stall;
    // Fetch advances unless frozen or holding the consumer of a load
    assign bus.pc_write       = !bus.hold && !stall;
    assign bus.ifid_write     = !bus.hold && !stall;

endmodule
